// File: rtl/rr_funnel_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_funnel_fifo                                                  |
// | Purpose  : Round-robin merge of NUM_CH valid/ready channels into one       |
// |            first-word-fall-through FIFO; each word carries its source tag. |
// | Revision : 1.0 - initial parametrised release                              |
// +----------------------------------------------------------------------------+
module rr_funnel_fifo #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4,
   localparam int CW    = $clog2(NUM_CH),
   localparam int NW    = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   inout  wire                     VDD,
   inout  wire                     VSS,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
   output logic [NUM_CH-1:0]       in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [CW-1:0]           out_chan,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NW-1:0]           count,
   output logic                    full,
   output logic                    empty
);

   localparam int            c_ptr_w   = $clog2(DEPTH);
   localparam logic [CW-1:0] c_last_ch = CW'(NUM_CH - 1);
   localparam logic [NW-1:0] c_depth   = NW'(DEPTH);

   // Supply pins are carried for the physical hierarchy only.
   wire w_unused_supply = &{1'b0, VDD, VSS};

   logic [WIDTH-1:0]   r_mem_data [DEPTH];
   logic [CW-1:0]      r_mem_chan [DEPTH];
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [NW-1:0]      r_count;
   logic [CW-1:0]      r_rr_ptr;

   logic [NUM_CH-1:0]  w_req_hi;
   logic               w_found;
   logic [CW-1:0]      w_grant;
   logic [WIDTH-1:0]   w_push_data;
   logic               w_pop;
   logic               w_space;
   logic               w_push;

   // Requests at or above rr_ptr win first; otherwise fall back to the lowest valid.
   always_comb begin
      w_req_hi = '0;
      w_found  = 1'b0;
      w_grant  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_req_hi[c] = in_valid[c] && (CW'(c) >= r_rr_ptr);
      end
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (in_valid[c]) begin
            w_found = 1'b1;
            w_grant = CW'(c);
         end
      end
      if (|w_req_hi) begin
         for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (w_req_hi[c]) begin
               w_grant = CW'(c);
            end
         end
      end
   end

   always_comb begin
      w_push_data = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_grant == CW'(c)) begin
            w_push_data = in_data[c*WIDTH +: WIDTH];
         end
      end
   end

   assign out_valid = rst_n && (r_count != '0);
   assign w_pop     = out_valid && out_ready;
   assign w_space   = (r_count != c_depth) || w_pop;
   assign w_push    = rst_n && w_space && w_found;

   always_comb begin
      in_ready = '0;
      if (w_push) begin
         in_ready[w_grant] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_rr_ptr <= '0;
      end else begin
         if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_chan[r_wr_ptr] <= w_grant;
            r_wr_ptr             <= r_wr_ptr + 1'b1;
            r_rr_ptr             <= (w_grant == c_last_ch) ? '0 : w_grant + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign out_data = r_mem_data[r_rd_ptr];
   assign out_chan = r_mem_chan[r_rd_ptr];
   assign count    = r_count;
   assign full     = (r_count == c_depth);
   assign empty    = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_rr_funnel_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rr_funnel_fifo                                               |
// | Purpose  : Random and directed stimulus against a queue-based model.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_rr_funnel_fifo;

   localparam int NUM_CH = 4;
   localparam int WIDTH  = 8;
   localparam int DEPTH  = 4;
   localparam int CW     = $clog2(NUM_CH);
   localparam int NW     = $clog2(DEPTH + 1);

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   wire                     vdd;
   wire                     vss;
   logic [NUM_CH*WIDTH-1:0] in_data = '0;
   logic [NUM_CH-1:0]       in_valid = '0;
   logic [NUM_CH-1:0]       in_ready;
   logic [WIDTH-1:0]        out_data;
   logic [CW-1:0]           out_chan;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [NW-1:0]           count;
   logic                    full;
   logic                    empty;

   assign vdd = 1'b1;
   assign vss = 1'b0;

   rr_funnel_fifo #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .VDD(vdd), .VSS(vss),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
      .out_ready(out_ready), .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a plain queue of accepted words plus the priority pointer.
   int q_data[$];
   int q_chan[$];
   int m_rr = 0;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [NUM_CH*WIDTH-1:0] rand_data();
      logic [NUM_CH*WIDTH-1:0] d;
      for (int c = 0; c < NUM_CH; c++) d[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
      return d;
   endfunction

   task automatic do_cycle(input logic [NUM_CH-1:0] v, input logic [NUM_CH*WIDTH-1:0] d,
                           input logic r, input logic rst);
      int  occ;
      int  g;
      int  exp_ready;
      bit  exp_ovalid;
      bit  pop;
      bit  space;
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      rst_n     = rst;
      #1;
      occ        = q_data.size();
      exp_ovalid = rst && (occ > 0);
      pop        = exp_ovalid && r;
      space      = (occ < DEPTH) || pop;
      g          = -1;
      if (rst && space) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (g < 0 && v[(m_rr + k) % NUM_CH]) g = (m_rr + k) % NUM_CH;
         end
      end
      exp_ready = (g >= 0) ? (1 << g) : 0;
      check_eq("in_ready", 32'(in_ready), exp_ready);
      check_eq("out_valid", 32'(out_valid), 32'(exp_ovalid));
      if (exp_ovalid) begin
         check_eq("out_data", 32'(out_data), q_data[0]);
         check_eq("out_chan", 32'(out_chan), q_chan[0]);
      end
      check_eq("count", 32'(count), occ);
      check_eq("full", 32'(full), 32'(occ == DEPTH));
      check_eq("empty", 32'(empty), 32'(occ == 0));
      if (!rst) begin
         q_data.delete();
         q_chan.delete();
         m_rr = 0;
      end else begin
         if (pop) begin
            void'(q_data.pop_front());
            void'(q_chan.pop_front());
         end
         if (g >= 0) begin
            q_data.push_back(int'(d[g*WIDTH +: WIDTH]));
            q_chan.push_back(g);
            m_rr = (g + 1) % NUM_CH;
         end
      end
   endtask

   initial begin
      logic [NUM_CH*WIDTH-1:0] fixed;
      logic [NUM_CH-1:0]       v;
      int                      pv;
      int                      pr;
      fixed = {8'h40, 8'h30, 8'h20, 8'h10};

      do_cycle('0, '0, 1'b0, 1'b0);
      do_cycle('0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) do_cycle('0, rand_data(), 1'b1, 1'b1);

      // Single word from channel 2 and its drain.
      do_cycle(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) do_cycle('0, rand_data(), 1'b1, 1'b1);

      // All channels valid, no backpressure: rotating grants.
      for (int i = 0; i < 12; i++) do_cycle('1, fixed, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) do_cycle('0, fixed, 1'b1, 1'b1);

      // Fill from channel 1, then pop and push together while full.
      for (int i = 0; i < 6; i++) do_cycle(4'b0010, rand_data(), 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) do_cycle(4'b0010, rand_data(), 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) do_cycle('0, rand_data(), 1'b1, 1'b1);

      // Reset mid-stream with requests pending.
      for (int i = 0; i < 3; i++) do_cycle(4'b1000, rand_data(), 1'b0, 1'b1);
      do_cycle('1, rand_data(), 1'b1, 1'b0);
      do_cycle(4'b1010, rand_data(), 1'b0, 1'b1);
      do_cycle('0, rand_data(), 1'b1, 1'b1);

      // Random traffic across several load profiles.
      for (int ph = 0; ph < 4; ph++) begin
         case (ph)
            0: begin pv = 80; pr = 80; end
            1: begin pv = 90; pr = 25; end
            2: begin pv = 20; pr = 90; end
            default: begin pv = 50; pr = 50; end
         endcase
         for (int i = 0; i < 120; i++) begin
            for (int c = 0; c < NUM_CH; c++) v[c] = ($urandom_range(0, 99) < pv);
            do_cycle(v, rand_data(), ($urandom_range(0, 99) < pr), ($urandom_range(0, 99) != 0));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rr_funnel_fifo.md
Name: rr_funnel_fifo

Overview:
Parametrised successor to the fixed four-input wrapper blocks. It merges NUM_CH independent valid/ready input channels into one output stream. A round-robin arbiter selects the channel and a DEPTH-entry first-word-fall-through FIFO buffers accepted words. Each output word is tagged with its source channel. The block sits between per-channel producers and a single downstream consumer in the physical netlist hierarchy, and carries VDD/VSS like every other .phy.v block.

Parameters:
NUM_CH, 4, number of input channels (>=2)
WIDTH, 8, data bits per channel
DEPTH, 4, FIFO entries (power of two, >=2)
CW, $clog2(NUM_CH), width of the channel tag (derived; not overridden)
NW, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden)

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
VDD  inout  1  power; no logical function
VSS  inout  1  ground; no logical function
in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  NUM_CH  per-channel valid
in_ready  output  NUM_CH  per-channel ready (one-hot or zero)
out_data  output  WIDTH  head-of-FIFO data
out_chan  output  CW  source channel of head word
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head word
count  output  NW  current occupancy, 0..DEPTH
full  output  1  count==DEPTH
empty  output  1  count==0

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-low, and sampled on the rising edge of clk.
  - Reset clears: rd_ptr=0, wr_ptr=0, count=0, rr_ptr=0 (channel 0 has highest priority).
  - While rst_n=0: in_ready=0 on all channels and out_valid=0.
  - After reset: empty=1, full=0, out_data and out_chan are don't-care while empty.
  - Reset asserted mid-stream discards all stored words. No handshake completes in a cycle where rst_n=0.
- pop = out_valid & out_ready.
- space = !full | pop. A push is allowed into a full FIFO in the same cycle as a pop.
- Arbiter (combinational):
  - If space=1, grant g = first channel with in_valid=1, searching rr_ptr, rr_ptr+1, ... mod NUM_CH.
  - in_ready[g]=1; all other in_ready bits are 0.
  - If space=0 or no channel is valid, in_ready=0.
  - in_ready may depend combinationally on in_valid and out_ready. Producers must not make in_valid depend on in_ready.
- Push: push = |(in_valid & in_ready).
  - Writes {g, in_data[g]} at wr_ptr; wr_ptr advances with wrap-around mod DEPTH.
  - rr_ptr <= (g+1) mod NUM_CH.
  - With no push, rr_ptr holds.
  - At most one push per cycle.
- Pop: head word is removed; rd_ptr advances mod DEPTH.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop: unchanged
  - neither: unchanged
- Latency: a word pushed into an empty FIFO appears at out_valid/out_data/out_chan on the next cycle. There is no same-cycle bypass.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_chan hold stable.
- Ordering: words leave in acceptance order. Per-channel order is preserved.
- Fairness: with all channels valid continuously and no backpressure, grants rotate 0,1,..,NUM_CH-1,0,...
- VDD/VSS are declared inout and connect to no logic.

Test Plan:
1. Reset then all in_valid=0 for 5 cycles -> in_ready=0, out_valid=0, empty=1, count=0 throughout.
2. Ch2 alone sends 0xA5 (in_valid[2]=1 for one cycle), out_ready=1 -> in_ready=4'b0100 in that cycle; next cycle out_valid=1, out_data=0xA5, out_chan=2; following cycle empty=1.
3. All four channels valid continuously with data 0x10,0x20,0x30,0x40, out_ready=1 -> grant order 0,1,2,3,0,1; out_chan sequence 0,1,2,3,0,1 one cycle later; count stays 1.
4. Ch1 valid with out_ready=0 -> 4 words accepted, then full=1, count=4, in_ready=0. Assert out_ready=1 -> in that cycle pop and push both occur, count stays 4, and out_data walks through the words in push order.
5. Fill 3 words, assert rst_n=0 for one cycle while in_valid=1 -> count=0, out_valid=0, no in_ready during reset. After release, the first grant goes to the lowest-numbered valid channel (rr_ptr=0).
6. Wrap-around: push and pop 10 words through DEPTH=4 with random out_ready -> output sequence equals input sequence, and count never exceeds 4 or underflows.
